// File: rtl/sram_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin SRAM arbiter.
// Array typedefs are sized from the defaults; the RTL itself is sized by module parameters.
package sram_arb_pkg;

    localparam int N_REQ_DEF  = 5;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int WAIT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } arb_state_t;

    typedef logic [N_REQ_DEF-1:0][ADDR_W_DEF-1:0] addr_arr_t;
    typedef logic [N_REQ_DEF-1:0][DATA_W_DEF-1:0] data_arr_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side and SRAM-side bus of the arbiter; master drives requests and SRAM read data.
interface sram_rr_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [N_REQ-1:0]             writeRequest;
    logic [N_REQ-1:0]             readRequest;
    logic [N_REQ-1:0][ADDR_W-1:0] ADDR;
    logic [N_REQ-1:0][DATA_W-1:0] DATA;
    logic [DATA_W-1:0]            SRAMdataIn;
    logic [DATA_W-1:0]            SRAMdataOut;
    logic                         SRAMdataOE;
    logic [ADDR_W-1:0]            addressToSRAM;
    logic                         SRAM_WE;
    logic                         SRAM_RE;
    logic [N_REQ-1:0]             grant;
    logic [DATA_W-1:0]            DataToCPUs;
    logic [N_REQ-1:0]             requestDone;

    modport master (
        output writeRequest, readRequest, ADDR, DATA, SRAMdataIn,
        input  SRAMdataOut, SRAMdataOE, addressToSRAM, SRAM_WE, SRAM_RE,
               grant, DataToCPUs, requestDone
    );

    modport slave (
        input  writeRequest, readRequest, ADDR, DATA, SRAMdataIn,
        output SRAMdataOut, SRAMdataOE, addressToSRAM, SRAM_WE, SRAM_RE,
               grant, DataToCPUs, requestDone
    );

endinterface

// File: rtl/sram_rr_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping to 0.
module rr_picker #(
    parameter int N_REQ = 5,
    parameter int PTR_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);
    localparam int SW = PTR_W + 1;

    always_comb begin
        logic [SW-1:0] pos;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        // Scan farthest offset first so the nearest set request overwrites earlier hits.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + SW'(i);
            if (pos >= SW'(N_REQ))
                pos = pos - SW'(N_REQ);
            if (req[pos[PTR_W-1:0]]) begin
                gnt                 = '0;
                gnt[pos[PTR_W-1:0]] = 1'b1;
                idx                 = pos[PTR_W-1:0];
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter letting N_REQ requesters share one asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1) -> DONE with the winner latched up front.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input logic               Clk,
    input logic               reset,
    sram_rr_arbiter_if.slave  bus
);
    localparam int PTR_W = ptr_w(N_REQ);

    arb_state_t        state, state_nxt;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_gnt;
    logic              win_wr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [N_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_vld;
    logic              access_last;

    logic [N_REQ-1:0]  grant_c;
    logic [N_REQ-1:0]  done_c;
    logic              we_c;
    logic              re_c;
    logic              oe_c;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (bus.writeRequest | bus.readRequest),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign access_last = (wait_cnt == WAIT_W'(WAIT_CYCLES));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_c   = '0;
        done_c    = '0;
        we_c      = 1'b1;
        re_c      = 1'b1;
        oe_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld)
                    state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                grant_c   = win_gnt;
                oe_c      = win_wr;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                grant_c = win_gnt;
                oe_c    = win_wr;
                we_c    = ~win_wr;
                re_c    = win_wr;
                if (access_last)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                grant_c   = win_gnt;
                done_c    = win_gnt;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Winner context is captured once so requesters may change inputs freely mid-access.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            win_idx  <= '0;
            win_gnt  <= '0;
            win_wr   <= 1'b0;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        win_idx  <= pick_idx;
                        win_gnt  <= pick_gnt;
                        win_wr   <= bus.writeRequest[pick_idx];
                        addr_q   <= bus.ADDR[pick_idx];
                        wdata_q  <= bus.DATA[pick_idx];
                        wait_cnt <= '0;
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (access_last && !win_wr)
                        rdata_q <= bus.SRAMdataIn;
                end
                ST_DONE: begin
                    rr_ptr <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant         = grant_c;
    assign bus.requestDone   = done_c;
    assign bus.SRAM_WE       = we_c;
    assign bus.SRAM_RE       = re_c;
    assign bus.SRAMdataOE    = oe_c;
    assign bus.addressToSRAM = addr_q;
    assign bus.SRAMdataOut   = wdata_q;
    assign bus.DataToCPUs    = rdata_q;

    a_strobe_excl: assert property (@(posedge Clk) disable iff (!reset) !(!we_c && !re_c));
    a_oe_vs_read:  assert property (@(posedge Clk) disable iff (!reset) !(oe_c && !re_c));
    a_grant_1hot:  assert property (@(posedge Clk) disable iff (!reset) $onehot0(grant_c));

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter with a small behavioural SRAM model.
module tb_sram_rr_arbiter;
    import sram_arb_pkg::*;

    localparam int N    = 5;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int WAIT = 1;
    localparam int LAT  = 3 + WAIT;

    typedef struct {
        int          idx;
        bit          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [DW-1:0] mem [0:255];

    sram_rr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_rr_arbiter #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .Clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.SRAMdataIn = !bus.SRAM_RE ? mem[bus.addressToSRAM[7:0]] : '0;
    always @(posedge clk)
        if (!bus.SRAM_WE && bus.SRAMdataOE)
            mem[bus.addressToSRAM[7:0]] <= bus.SRAMdataOut;

    task automatic wait_done(input int budget, output int cyc, output logic [N-1:0] dv);
        cyc = -1;
        dv  = '0;
        for (int c = 1; c <= budget && cyc < 0; c++) begin
            @(negedge clk);
            if (bus.requestDone != '0) begin
                cyc = c;
                dv  = bus.requestDone;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.writeRequest = '0;
        bus.readRequest  = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_chk++; if (bus.grant !== 5'b0)       begin n_fail++; $display("FAIL rst_grant got %b exp 00000", bus.grant); end
        n_chk++; if (bus.requestDone !== 5'b0) begin n_fail++; $display("FAIL rst_done got %b exp 00000", bus.requestDone); end
        n_chk++; if (bus.SRAM_WE !== 1'b1)     begin n_fail++; $display("FAIL rst_we got %b exp 1", bus.SRAM_WE); end
        n_chk++; if (bus.SRAM_RE !== 1'b1)     begin n_fail++; $display("FAIL rst_re got %b exp 1", bus.SRAM_RE); end
        n_chk++; if (bus.SRAMdataOE !== 1'b0)  begin n_fail++; $display("FAIL rst_oe got %b exp 0", bus.SRAMdataOE); end
        n_chk++; if (bus.addressToSRAM !== 16'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0000", bus.addressToSRAM); end
        n_chk++; if (bus.SRAMdataOut !== 16'h0)   begin n_fail++; $display("FAIL rst_dout got %h exp 0000", bus.SRAMdataOut); end
        n_chk++; if (bus.DataToCPUs !== 16'h0)    begin n_fail++; $display("FAIL rst_cpu_data got %h exp 0000", bus.DataToCPUs); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        exp_t e;
        logic exp_we;
        logic [N-1:0] exp_dn;
        @(negedge clk);
        bus.ADDR[2] = 16'h0010;
        bus.DATA[2] = 16'hBEEF;
        bus.writeRequest = 5'b00100;
        sb.push_back('{2, 1'b1, 16'h0010, 16'hBEEF});
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.ADDR[2] = 16'h0011;   // must not disturb the latched access
                bus.DATA[2] = 16'h0000;
            end
            exp_we = (c >= 2 && c <= 2 + WAIT) ? 1'b0 : 1'b1;
            n_chk++; if (bus.SRAM_WE !== exp_we) begin n_fail++; $display("FAIL wr_we c%0d got %b exp %b", c, bus.SRAM_WE, exp_we); end
            n_chk++; if (bus.SRAMdataOE !== (c < LAT)) begin n_fail++; $display("FAIL wr_oe c%0d got %b exp %b", c, bus.SRAMdataOE, (c < LAT)); end
            n_chk++; if (bus.addressToSRAM !== 16'h0010) begin n_fail++; $display("FAIL wr_addr c%0d got %h exp 0010", c, bus.addressToSRAM); end
            if (c >= 2 && c <= 2 + WAIT) begin
                n_chk++; if (bus.SRAMdataOut !== 16'hBEEF) begin n_fail++; $display("FAIL wr_dout c%0d got %h exp beef", c, bus.SRAMdataOut); end
            end
            if (c < LAT) begin
                n_chk++; if (bus.requestDone !== 5'b0) begin n_fail++; $display("FAIL wr_early_done c%0d got %b exp 00000", c, bus.requestDone); end
            end else begin
                e = sb.pop_front();
                exp_dn = '0; exp_dn[e.idx] = 1'b1;
                n_chk++; if (bus.requestDone !== exp_dn) begin n_fail++; $display("FAIL wr_done got %b exp %b", bus.requestDone, exp_dn); end
            end
        end
        bus.writeRequest = '0;
        @(negedge clk);
        n_chk++; if (bus.requestDone !== 5'b0) begin n_fail++; $display("FAIL wr_pulse_len got %b exp 00000", bus.requestDone); end
        n_chk++; if (mem[8'h10] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem got %h exp beef", mem[8'h10]); end
    endtask

    task automatic test_read();
        exp_t e;
        logic exp_re;
        logic [N-1:0] exp_dn;
        @(negedge clk);
        bus.ADDR[2] = 16'h0010;
        bus.readRequest = 5'b00100;
        sb.push_back('{2, 1'b0, 16'h0010, 16'hBEEF});
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            exp_re = (c >= 2 && c <= 2 + WAIT) ? 1'b0 : 1'b1;
            n_chk++; if (bus.SRAM_RE !== exp_re) begin n_fail++; $display("FAIL rd_re c%0d got %b exp %b", c, bus.SRAM_RE, exp_re); end
            n_chk++; if (bus.SRAMdataOE !== 1'b0) begin n_fail++; $display("FAIL rd_oe c%0d got %b exp 0", c, bus.SRAMdataOE); end
            n_chk++; if (bus.SRAM_WE !== 1'b1) begin n_fail++; $display("FAIL rd_we c%0d got %b exp 1", c, bus.SRAM_WE); end
            if (c == LAT) begin
                e = sb.pop_front();
                exp_dn = '0; exp_dn[e.idx] = 1'b1;
                n_chk++; if (bus.requestDone !== exp_dn) begin n_fail++; $display("FAIL rd_done got %b exp %b", bus.requestDone, exp_dn); end
                n_chk++; if (bus.DataToCPUs !== e.data) begin n_fail++; $display("FAIL rd_data got %h exp %h", bus.DataToCPUs, e.data); end
            end
        end
        bus.readRequest = '0;
        @(negedge clk);
        n_chk++; if (bus.DataToCPUs !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data_hold got %h exp beef", bus.DataToCPUs); end
    endtask

    task automatic test_all_five(input bit wr);
        exp_t e;
        int   c;
        int   last;
        logic [N-1:0] exp_dn;
        if (wr) apply_reset();
        else    @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bus.ADDR[i] = AW'(16'h0040 + i);
            bus.DATA[i] = DW'(16'hA000 + i * 16'h0111);
            sb.push_back('{i, wr, AW'(16'h0040 + i), DW'(16'hA000 + i * 16'h0111)});
        end
        if (wr) bus.writeRequest = '1;
        else    bus.readRequest  = '1;
        c = 0;
        last = 0;
        while (sb.size() != 0 && c < 8 * N * (LAT + 1)) begin
            @(negedge clk);
            c++;
            n_chk++;
            if (!$onehot0(bus.grant) || (!bus.SRAM_WE && !bus.SRAM_RE) || (bus.SRAMdataOE && !bus.SRAM_RE)) begin
                n_fail++;
                $display("FAIL all5_bus c%0d grant %b we %b re %b oe %b", c, bus.grant, bus.SRAM_WE, bus.SRAM_RE, bus.SRAMdataOE);
            end
            if (bus.requestDone != '0) begin
                e = sb.pop_front();
                exp_dn = '0; exp_dn[e.idx] = 1'b1;
                n_chk++; if (bus.requestDone !== exp_dn) begin n_fail++; $display("FAIL all5_order wr%0d got %b exp %b", wr, bus.requestDone, exp_dn); end
                n_chk++; if (c - last != ((last == 0) ? LAT : LAT + 1)) begin n_fail++; $display("FAIL all5_spacing wr%0d got %0d exp %0d", wr, c - last, (last == 0) ? LAT : LAT + 1); end
                if (!wr) begin
                    n_chk++; if (bus.DataToCPUs !== e.data) begin n_fail++; $display("FAIL all5_rdata idx%0d got %h exp %h", e.idx, bus.DataToCPUs, e.data); end
                end
                if (wr) bus.writeRequest[e.idx] = 1'b0;
                else    bus.readRequest[e.idx]  = 1'b0;
                last = c;
            end
        end
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL all5_timeout wr%0d got %0d pending exp 0", wr, sb.size()); end
        sb.delete();
        bus.writeRequest = '0;
        bus.readRequest  = '0;
    endtask

    task automatic test_rr_pointer();
        exp_t e;
        int   cyc;
        logic [N-1:0] dv, exp_dn;
        @(negedge clk);
        bus.ADDR[2] = 16'h0050;
        bus.DATA[2] = 16'h5555;
        bus.writeRequest = 5'b00100;
        sb.push_back('{2, 1'b1, 16'h0050, 16'h5555});
        wait_done(LAT + 2, cyc, dv);
        e = sb.pop_front();
        exp_dn = '0; exp_dn[e.idx] = 1'b1;
        n_chk++; if (dv !== exp_dn || cyc != LAT) begin n_fail++; $display("FAIL rr_setup got %b@%0d exp %b@%0d", dv, cyc, exp_dn, LAT); end
        bus.writeRequest = '0;
        @(negedge clk);
        bus.ADDR[0] = 16'h0040;
        bus.ADDR[3] = 16'h0043;
        bus.readRequest = 5'b01001;
        sb.push_back('{3, 1'b0, 16'h0043, 16'hA333});
        sb.push_back('{0, 1'b0, 16'h0040, 16'hA000});
        for (int k = 0; k < 2; k++) begin
            wait_done(LAT + 2, cyc, dv);
            e = sb.pop_front();
            exp_dn = '0; exp_dn[e.idx] = 1'b1;
            n_chk++; if (dv !== exp_dn) begin n_fail++; $display("FAIL rr_order k%0d got %b exp %b", k, dv, exp_dn); end
            n_chk++; if (bus.DataToCPUs !== e.data) begin n_fail++; $display("FAIL rr_data k%0d got %h exp %h", k, bus.DataToCPUs, e.data); end
            bus.readRequest[e.idx] = 1'b0;
        end
        bus.readRequest = '0;
    endtask

    task automatic test_rw_same();
        exp_t e;
        int   cyc;
        logic [N-1:0] dv, exp_dn;
        @(negedge clk);
        bus.ADDR[1] = 16'h0060;
        bus.DATA[1] = 16'h6161;
        bus.writeRequest = 5'b00010;
        bus.readRequest  = 5'b00010;
        sb.push_back('{1, 1'b1, 16'h0060, 16'h6161});
        sb.push_back('{1, 1'b0, 16'h0060, 16'h6161});
        for (int k = 0; k < 2; k++) begin
            wait_done(LAT + 2, cyc, dv);
            e = sb.pop_front();
            exp_dn = '0; exp_dn[e.idx] = 1'b1;
            n_chk++; if (dv !== exp_dn) begin n_fail++; $display("FAIL rw_done k%0d got %b exp %b", k, dv, exp_dn); end
            if (e.wr) begin
                n_chk++; if (mem[8'h60] !== e.data) begin n_fail++; $display("FAIL rw_write_first got %h exp %h", mem[8'h60], e.data); end
                bus.writeRequest[e.idx] = 1'b0;
            end else begin
                n_chk++; if (bus.DataToCPUs !== e.data) begin n_fail++; $display("FAIL rw_read_second got %h exp %h", bus.DataToCPUs, e.data); end
                bus.readRequest[e.idx] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        logic [N-1:0] dv, exp_dn;
        @(negedge clk);
        bus.ADDR[4] = 16'h0020;
        bus.DATA[4] = 16'h1234;
        bus.writeRequest = 5'b10000;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (bus.SRAM_WE !== 1'b0) begin n_fail++; $display("FAIL mid_in_access got %b exp 0", bus.SRAM_WE); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (bus.SRAM_WE !== 1'b1 || bus.SRAM_RE !== 1'b1) begin n_fail++; $display("FAIL mid_strobes got %b%b exp 11", bus.SRAM_WE, bus.SRAM_RE); end
        n_chk++; if (bus.grant !== 5'b0) begin n_fail++; $display("FAIL mid_grant got %b exp 00000", bus.grant); end
        n_chk++; if (bus.SRAMdataOE !== 1'b0) begin n_fail++; $display("FAIL mid_oe got %b exp 0", bus.SRAMdataOE); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++; if (bus.requestDone !== 5'b0) begin n_fail++; $display("FAIL mid_no_done k%0d got %b exp 00000", k, bus.requestDone); end
        end
        rst_n = 1'b1;
        sb.push_back('{4, 1'b1, 16'h0020, 16'h1234});
        wait_done(LAT + 2, cyc, dv);
        e = sb.pop_front();
        exp_dn = '0; exp_dn[e.idx] = 1'b1;
        n_chk++; if (dv !== exp_dn || cyc != LAT) begin n_fail++; $display("FAIL mid_reserve got %b@%0d exp %b@%0d", dv, cyc, exp_dn, LAT); end
        bus.writeRequest = '0;
        @(negedge clk);
        n_chk++; if (mem[8'h20] !== e.data) begin n_fail++; $display("FAIL mid_mem got %h exp %h", mem[8'h20], e.data); end
    endtask

    initial begin
        bus.writeRequest = '0;
        bus.readRequest  = '0;
        bus.ADDR         = '0;
        bus.DATA         = '0;
        test_reset();
        test_write();
        test_read();
        test_all_five(1'b1);
        test_all_five(1'b0);
        test_rr_pointer();
        test_rw_same();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 5, number of CPU requesters sharing the SRAM.
REQ-002 Parameter ADDR_W, default 16, SRAM/requester address width.
REQ-003 Parameter DATA_W, default 16, SRAM/requester data width.
REQ-004 Parameter WAIT_CYCLES, default 1, extra strobe cycles per access (0..7).
REQ-005 Clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 writeRequest  input  N_REQ  per-requester write request, level, held until done.
REQ-008 readRequest  input  N_REQ  per-requester read request, level, held until done.
REQ-009 ADDR  input  N_REQ x ADDR_W  per-requester address (package array type).
REQ-010 DATA  input  N_REQ x DATA_W  per-requester write data (package array type).
REQ-011 SRAMdataIn  input  DATA_W  data returned from the external tristate.
REQ-012 SRAMdataOut  output  DATA_W  write data to the tristate.
REQ-013 SRAMdataOE  output  1  tristate drive enable, high only during write SETUP/ACCESS.
REQ-014 addressToSRAM  output  ADDR_W  SRAM address.
REQ-015 SRAM_WE, SRAM_RE  output  1 each  active-low write/read strobes.
REQ-016 grant  output  N_REQ  one-hot owner of the current access, zero when idle.
REQ-017 DataToCPUs  output  DATA_W  registered read data, valid from the done cycle until the next read completes.
REQ-018 requestDone  output  N_REQ  one-cycle one-hot completion pulse.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS, DONE; IDLE->SETUP when any request (read|write) is set, else stay.
REQ-020 In IDLE, the winner is the first set request at or after pointer rr_ptr, wrapping N_REQ-1 -> 0.
REQ-021 Winner's index, address, data and direction are latched on IDLE->SETUP; later input changes do not affect the access.
REQ-022 Write and read set for the same requester in the same cycle: write is performed; read stays pending.
REQ-023 SETUP lasts 1 cycle: address and grant driven, both strobes high, OE high for writes.
REQ-024 ACCESS lasts WAIT_CYCLES+1 cycles with SRAM_WE (write) or SRAM_RE (read) low, address and data stable.
REQ-025 Read data sampled from SRAMdataIn on the last ACCESS cycle and registered into DataToCPUs on entry to DONE.
REQ-026 DONE lasts 1 cycle: requestDone[winner]=1, strobes high, OE low; rr_ptr <= winner+1 mod N_REQ; then IDLE.
REQ-027 Latency, request first seen in IDLE at cycle 0: done pulse in cycle 3+WAIT_CYCLES (cycle 4 at default).
REQ-028 Requesters drop the request in the cycle after done; a request still set then is treated as a new request.
REQ-029 A request deasserted mid-access does not abort it; the access completes and done still pulses.
REQ-030 Strobes are never both low; OE is never high while SRAM_RE is low.
REQ-031 No starvation: any held request completes within N_REQ accesses.

Reset
REQ-032 reset low asynchronously forces IDLE, rr_ptr=0, grant=0, requestDone=0, SRAM_WE=SRAM_RE=1, SRAMdataOE=0, addressToSRAM=0, SRAMdataOut=0, DataToCPUs=0.
REQ-033 Reset mid-access abandons the access with no done pulse; operation resumes on the first edge after release.

Structure
REQ-034 Package sram_arb_pkg holds N_REQ, ADDR_W, DATA_W defaults, the state enum and the addr/data array typedefs.
REQ-035 One sub-module, rr_picker: combinational round-robin selector (request vector, pointer -> one-hot winner, valid).

Verification
REQ-036 Write only: writeRequest=5'b00100, ADDR2=16'h0010, DATA2=16'hBEEF -> SRAM_WE low cycles 2-3, addressToSRAM=16'h0010, requestDone=5'b00100 in cycle 4; memory holds BEEF.
REQ-037 Read back: readRequest=5'b00100, ADDR2=16'h0010 -> SRAM_RE low cycles 2-3, OE low throughout, DataToCPUs=16'hBEEF with done in cycle 4.
REQ-038 All five requests at once from reset -> done order 0,1,2,3,4, one access per 5 cycles, grant always one-hot.
REQ-039 rr_ptr=3, requests 5'b01001 -> requester 3 served first, then 0.
REQ-040 Read and write both set on requester 1 -> write done first, read done on the next access.
REQ-041 reset asserted during ACCESS -> strobes high and grant=0 immediately, no requestDone; a held request is re-served from IDLE after release.
